// File: rtl/instr_trace_buf.sv
// ============================================================================
// Module : instr_trace_buf
// Captures {pc, inst, seq} on each instr_change rising edge into a
// first-word-fall-through FIFO, counting captures dropped while full.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_trace_buf #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       instr_change,
  input  logic [31:0]                pc,
  input  logic [31:0]                inst,
  input  logic                       clear,
  input  logic                       trace_ready,
  output logic                       trace_valid,
  output logic [31:0]                trace_pc,
  output logic [31:0]                trace_inst,
  output logic [15:0]                trace_seq,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [15:0]                overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [79:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [15:0]   seq_next;
  logic [15:0]   ovf_q;
  logic          prev;

  logic rise;
  logic pop;
  logic push;
  logic drop;

  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_COUNT);
  assign count        = count_q;
  assign overflow_cnt = ovf_q;
  assign trace_valid  = ~empty;

  assign rise = instr_change & ~prev;
  assign pop  = trace_valid & trace_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push = rise & (~full | pop);
  assign drop = rise & full & ~pop;

  assign {trace_pc, trace_inst, trace_seq} = mem[rd_ptr];

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      prev     <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      seq_next <= '0;
      ovf_q    <= '0;
    end else begin
      prev <= instr_change;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count_q  <= '0;
        seq_next <= '0;
        ovf_q    <= '0;
      end else begin
        if (rise) seq_next <= seq_next + 16'd1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
        if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      end
    end
  end

  // Storage is not reset; validity is tracked solely by count.
  always_ff @(posedge clk_in) begin
    if (push && !clear) mem[wr_ptr] <= {pc, inst, seq_next};
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_trace_buf.sv
// ============================================================================
// Module : tb_instr_trace_buf
// Directed self-checking bench for instr_trace_buf (DEPTH=16).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_trace_buf;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        instr_change;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        clear;
  logic        trace_ready;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;
  logic [15:0] trace_seq;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] overflow_cnt;

  int total = 0;
  int bad   = 0;

  instr_trace_buf #(.DEPTH(16)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .instr_change (instr_change),
    .pc           (pc),
    .inst         (inst),
    .clear        (clear),
    .trace_ready  (trace_ready),
    .trace_valid  (trace_valid),
    .trace_pc     (trace_pc),
    .trace_inst   (trace_inst),
    .trace_seq    (trace_seq),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One-cycle high strobe followed by one low cycle.
  task automatic pulse(input logic [31:0] p, input logic [31:0] i);
    pc = p;
    inst = i;
    instr_change = 1'b1;
    tick();
    instr_change = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    instr_change = 1'b0;
    pc = '0;
    inst = '0;
    clear = 1'b0;
    trace_ready = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_valid", 32'(trace_valid), 32'd0);
    chk("rst_ovf",   32'(overflow_cnt), 32'd0);
    #2 reset = 1'b1;
    tick();

    // First capture: 1-cycle latency into empty FIFO
    pc = 32'h0040_0000;
    inst = 32'h2401_0001;
    instr_change = 1'b1;
    tick();
    instr_change = 1'b0;
    chk("first_valid", 32'(trace_valid), 32'd1);
    chk("first_pc",    trace_pc, 32'h0040_0000);
    chk("first_inst",  trace_inst, 32'h2401_0001);
    chk("first_seq",   32'(trace_seq), 32'd0);
    chk("first_count", 32'(count), 32'd1);
    tick();
    do_clear();
    chk("clr_empty", 32'(empty), 32'd1);

    // 17 pulses: 16 stored, one dropped
    for (int k = 0; k < 17; k++) pulse(32'h1000 + 32'(k) * 4, 32'hA000_0000 + 32'(k));
    chk("ovf17_full",  32'(full), 32'd1);
    chk("ovf17_count", 32'(count), 32'd16);
    chk("ovf17_ovf",   32'(overflow_cnt), 32'd1);
    trace_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_seq", 32'(trace_seq), 32'(k));
      chk("drain_pc",  trace_pc, 32'h1000 + 32'(k) * 4);
      tick();
    end
    trace_ready = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_valid", 32'(trace_valid), 32'd0);

    // 3 entries (seq continues 17..19), then clear with a coincident pulse
    for (int k = 0; k < 3; k++) pulse(32'h2000 + 32'(k), 32'h0);
    chk("pre_clr_count", 32'(count), 32'd3);
    chk("pre_clr_seq",   32'(trace_seq), 32'd17);
    chk("pre_clr_ovf",   32'(overflow_cnt), 32'd1);
    instr_change = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    instr_change = 1'b0;
    chk("clr_pulse_empty", 32'(empty), 32'd1);
    chk("clr_pulse_ovf",   32'(overflow_cnt), 32'd0);
    tick();
    pulse(32'h3000, 32'h3);
    chk("after_clr_seq",   32'(trace_seq), 32'd0);
    chk("after_clr_count", 32'(count), 32'd1);

    // Full FIFO: rise and pop in the same cycle
    do_clear();
    for (int k = 0; k < 16; k++) pulse(32'h4000 + 32'(k), 32'h0);
    chk("fp_full", 32'(full), 32'd1);
    instr_change = 1'b1;
    pc = 32'h4444;
    trace_ready = 1'b1;
    tick();
    instr_change = 1'b0;
    trace_ready = 1'b0;
    chk("fp_count", 32'(count), 32'd16);
    chk("fp_ovf",   32'(overflow_cnt), 32'd0);
    chk("fp_head",  32'(trace_seq), 32'd1);
    trace_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk("fp_drain_seq", 32'(trace_seq), 32'(k));
      tick();
    end
    trace_ready = 1'b0;
    chk("fp_drain_empty", 32'(empty), 32'd1);

    // Mid-depth rise plus pop keeps count
    pulse(32'h5000, 32'h0);
    pulse(32'h5001, 32'h0);
    instr_change = 1'b1;
    trace_ready = 1'b1;
    tick();
    instr_change = 1'b0;
    trace_ready = 1'b0;
    chk("mid_rp_count", 32'(count), 32'd2);
    chk("mid_rp_pc",    trace_pc, 32'h5001);

    // Level-high strobe is one capture
    do_clear();
    instr_change = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    instr_change = 1'b0;
    tick();
    pulse(32'h6000, 32'h0);
    chk("lvl_count", 32'(count), 32'd2);
    chk("lvl_seq0",  32'(trace_seq), 32'd0);
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    chk("lvl_seq1", 32'(trace_seq), 32'd1);
    chk("lvl_pc1",  trace_pc, 32'h6000);

    // Asynchronous reset mid-operation
    do_clear();
    for (int k = 0; k < 5; k++) pulse(32'h7000 + 32'(k), 32'h0);
    chk("ar_pre_count", 32'(count), 32'd5);
    #2;
    instr_change = 1'b1;
    reset = 1'b0;
    #1;
    chk("ar_valid", 32'(trace_valid), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    #2 reset = 1'b1;
    tick();
    tick();
    tick();
    chk("ar_no_capture", 32'(count), 32'd0);
    instr_change = 1'b0;
    tick();
    pulse(32'h8000, 32'h8);
    chk("ar_seq0", 32'(trace_seq), 32'd0);
    chk("ar_pc",   trace_pc, 32'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
